tt_um_chandrakanth_4_2_encoder: RTL

Sequential 4-to-2 priority encoder. It is the encode-side counterpart of the team's 2-to-4 decoder tile.
- Watches four request lines on ui_in, synchronises them and detects rising edges.
- Captures the highest-priority new request as a 2-bit code.
- Holds the code with a valid flag until the host acknowledges it.
- Tracks a multi-hot flag, a sticky overflow flag and a 4-bit event counter.
- Standard TinyTapeout user tile; it plugs into the same tb wrapper used by the decoder.

---
 rtl/tt_um_chandrakanth_4_2_encoder.sv | 73 +++++++
 1 files changed

// File: rtl/tt_um_chandrakanth_4_2_encoder.sv
// tt_um_chandrakanth_4_2_encoder: sequential 4-to-2 priority encoder tile
//   ui_in[3:0] req d0..d3, ui_in[4] ack, ui_in[5] clear, ui_in[7:6] unused
//   uo_out[1:0] code, [2] valid, [3] multi, [4] overflow, [7:5] zero
//   uio_out[3:0] event count, [7:4] zero; uio_oe fixed 8'h0F; uio_in unused
//   ena masks request/ack edges; rst_n asynchronous active-low
module tt_um_chandrakanth_4_2_encoder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t      state;
    logic [5:0]  sync [SYNC_STAGES];
    logic [3:0]  req_s, req_prev, rise, count;
    logic        ack_s, ack_prev, clr_s, ack_edge, valid, multi, overflow;
    logic [1:0]  code, enc;
    logic        multi_n;
    logic        unused;
    assign req_s    = sync[SYNC_STAGES-1][3:0];
    assign ack_s    = sync[SYNC_STAGES-1][4];
    assign clr_s    = sync[SYNC_STAGES-1][5];
    // prev registers track the line even while masked, so re-enabling never fakes an edge
    assign rise     = ena ? req_s & ~req_prev : 4'h0;
    assign ack_edge = ena & ack_s & ~ack_prev;
    assign enc      = rise[3] ? 2'd3 : rise[2] ? 2'd2 : rise[1] ? 2'd1 : 2'd0;
    assign multi_n  = $countones(req_s) > 1;
    assign uo_out   = {3'b000, overflow, multi, valid, code};
    assign uio_out  = {4'h0, count};
    assign uio_oe   = 8'h0F;
    assign unused   = &{1'b0, uio_in, ui_in[7:6]};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
            req_prev <= '0;
            ack_prev <= 1'b0;
            state    <= IDLE;
            code     <= '0;
            valid    <= 1'b0;
            multi    <= 1'b0;
            overflow <= 1'b0;
            count    <= '0;
        end else begin
            sync[0] <= ui_in[5:0];
            for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
            req_prev <= req_s;
            ack_prev <= ack_s;
            if (|rise && (state == IDLE || ack_edge)) begin
                code  <= enc;
                multi <= multi_n;
                valid <= 1'b1;
                count <= count + 4'd1;
                state <= HOLD;
            end else if (state == HOLD && ack_edge) begin
                valid <= 1'b0;
                state <= IDLE;
            end else if (state == HOLD && |rise) begin
                overflow <= 1'b1;
            end
            // clear is last so it overrides a same-cycle increment or overflow
            if (clr_s) begin
                count    <= '0;
                overflow <= 1'b0;
            end
        end
    end
endmodule
